resp_serializer: RTL and testbench

Transmit-side counterpart of the command gather path. Pops one response packet from the response FIFO and serializes it, byte by byte, into a framed stream in the TX byte FIFO, which feeds uart_tx. The block sits between the command execution / response FIFO and the TX byte_fifo. It honours byte-FIFO backpressure and never drops or duplicates bytes.

---
 rtl/cmd_pkg.sv | 22 ++
 rtl/resp_serializer.sv | 143 ++++++++++++++
 tb/tb_resp_serializer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmd_pkg.sv
// Shared command/response types for the UART command path.
// The response side defines the packet struct, frame sizes and serializer states.
package cmd_pkg;

  localparam logic [7:0]  RESP_SOF        = 8'hA5;
  localparam int unsigned RESP_LEN_NODATA = 3;
  localparam int unsigned RESP_LEN_DATA   = 7;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [7:0]  status;
    logic        has_data;
    logic [31:0] data;
  } resp_packet_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } resp_state_t;

endpackage

// File: rtl/resp_serializer.sv
// Pops one response packet and writes it as a framed byte stream into the TX byte FIFO.
// Build option RESP_CHECKSUM_EN appends an XOR checksum byte (all bytes except SOF).
module resp_serializer
  import cmd_pkg::*;
#(
  parameter logic [7:0]  SOF_BYTE   = RESP_SOF,
  parameter int unsigned DATA_BYTES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         resp_fifo_valid,
  input  resp_packet_t resp_fifo_data,
  output logic         resp_fifo_rd_en,
  input  logic         byte_fifo_full,
  output logic         byte_fifo_wr_en,
  output logic [7:0]   byte_fifo_wr_data,
  output logic         busy,
  output logic         frame_done
);

`ifdef RESP_CHECKSUM_EN
  localparam int unsigned CSUM_BYTES = 1;
`else
  localparam int unsigned CSUM_BYTES = 0;
`endif

  localparam logic [2:0] LAST_NODATA = 3'(RESP_LEN_NODATA - 1 + CSUM_BYTES);
  localparam logic [2:0] LAST_DATA   = 3'(RESP_LEN_NODATA - 1 + DATA_BYTES + CSUM_BYTES);

  resp_state_t  state_q, state_d;
  resp_packet_t shadow_q, shadow_d;
  logic [2:0]   idx_q, idx_d;
  logic [2:0]   last_idx_q, last_idx_d;
  logic         rd_en_q, rd_en_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
`ifdef RESP_CHECKSUM_EN
  logic [7:0]   csum_q, csum_d;
`endif

  logic [7:0] frame_byte;
  logic       wr_accept;

  // Handshake: a byte moves into the TX FIFO in any SEND cycle where the FIFO is not full.
  assign wr_accept         = (state_q == SEND) && !byte_fifo_full;
  assign byte_fifo_wr_en   = wr_accept;
  assign byte_fifo_wr_data = wr_accept ? frame_byte : 8'h00;
  assign resp_fifo_rd_en   = rd_en_q;
  assign busy              = busy_q;
  assign frame_done        = done_q;

  always_comb begin
    frame_byte = 8'h00;
    case (idx_q)
      3'd0:    frame_byte = SOF_BYTE;
      3'd1:    frame_byte = shadow_q.opcode;
      3'd2:    frame_byte = shadow_q.status;
      3'd3:    frame_byte = shadow_q.data[31:24];
      3'd4:    frame_byte = shadow_q.data[23:16];
      3'd5:    frame_byte = shadow_q.data[15:8];
      3'd6:    frame_byte = shadow_q.data[7:0];
      default: frame_byte = 8'h00;
    endcase
`ifdef RESP_CHECKSUM_EN
    if (idx_q == last_idx_q) frame_byte = csum_q;
`endif
  end

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    idx_d      = idx_q;
    last_idx_d = last_idx_q;
    rd_en_d    = 1'b0;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef RESP_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (resp_fifo_valid) begin
          shadow_d   = resp_fifo_data;
          idx_d      = 3'd0;
          last_idx_d = resp_fifo_data.has_data ? LAST_DATA : LAST_NODATA;
          rd_en_d    = 1'b1;
          busy_d     = 1'b1;
          state_d    = SEND;
`ifdef RESP_CHECKSUM_EN
          csum_d     = 8'h00;
`endif
        end
      end
      SEND: begin
        if (wr_accept) begin
          idx_d = idx_q + 3'd1;
`ifdef RESP_CHECKSUM_EN
          if (idx_q != 3'd0) csum_d = csum_q ^ frame_byte;
`endif
          if (idx_q == last_idx_q) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      idx_q      <= 3'd0;
      last_idx_q <= 3'd0;
      rd_en_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef RESP_CHECKSUM_EN
      csum_q     <= 8'h00;
`endif
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      idx_q      <= idx_d;
      last_idx_q <= last_idx_d;
      rd_en_q    <= rd_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef RESP_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

endmodule

// File: tb/tb_resp_serializer.sv
// Bench for resp_serializer: a queue-based response FIFO feeds packets, a monitor collects
// written bytes, and each scenario compares against frames built from the framing rules.
module tb_resp_serializer;
  import cmd_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         resp_fifo_valid;
  resp_packet_t resp_fifo_data;
  logic         resp_fifo_rd_en;
  logic         byte_fifo_full;
  logic         byte_fifo_wr_en;
  logic [7:0]   byte_fifo_wr_data;
  logic         busy;
  logic         frame_done;

  resp_serializer dut (
    .clk               (clk),
    .rst               (rst),
    .resp_fifo_valid   (resp_fifo_valid),
    .resp_fifo_data    (resp_fifo_data),
    .resp_fifo_rd_en   (resp_fifo_rd_en),
    .byte_fifo_full    (byte_fifo_full),
    .byte_fifo_wr_en   (byte_fifo_wr_en),
    .byte_fifo_wr_data (byte_fifo_wr_data),
    .busy              (busy),
    .frame_done        (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    int         c;
  } obs_t;

  int           checks   = 0;
  int           failures = 0;
  int           cyc      = 0;
  int           rd_cnt   = 0;
  int           done_cnt = 0;
  int           proto_err = 0;
  int           busy_err = 0;
  obs_t         obs_q[$];
  logic [7:0]   exp_q[$];
  int           done_cyc_q[$];
  resp_packet_t pkt_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic resp_packet_t rand_pkt();
    resp_packet_t p;
    p.opcode   = 8'($urandom_range(0, 255));
    p.status   = 8'($urandom_range(0, 255));
    p.has_data = 1'($urandom_range(0, 1));
    p.data     = $urandom;
    return p;
  endfunction

  // Reference framing: SOF, opcode, status, optional data MSB first, optional XOR checksum.
  function automatic void build_frame(input resp_packet_t p);
    logic [7:0] f[$];
    f.push_back(8'hA5);
    f.push_back(p.opcode);
    f.push_back(p.status);
    if (p.has_data)
      for (int k = 3; k >= 0; k--) f.push_back(p.data[8*k +: 8]);
`ifdef RESP_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 1; i < f.size(); i++) x = x ^ f[i];
      f.push_back(x);
    end
`endif
    foreach (f[i]) exp_q.push_back(f[i]);
  endfunction

  // Monitor plus response FIFO model; the head is popped on each rd_en pulse.
  always @(negedge clk) begin
    if (byte_fifo_wr_en) obs_q.push_back('{b: byte_fifo_wr_data, c: cyc});
    if ((byte_fifo_wr_en && byte_fifo_full) || (!byte_fifo_wr_en && byte_fifo_wr_data !== 8'h00))
      proto_err <= proto_err + 1;
    if (resp_fifo_rd_en) begin
      rd_cnt <= rd_cnt + 1;
      if (pkt_q.size() > 0) void'(pkt_q.pop_front());
    end
    if (frame_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc_q.push_back(cyc);
    end
    if ((frame_done && busy) || (resp_fifo_rd_en && !busy)) busy_err <= busy_err + 1;
    resp_fifo_valid <= (pkt_q.size() > 0);
    resp_fifo_data  <= (pkt_q.size() > 0) ? pkt_q[0] : rand_pkt();
  end

  task automatic clear_obs();
    obs_q.delete();
    exp_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic wait_bytes(input int n, input bit rand_full);
    int k = 0;
    while (obs_q.size() < n && k < 3000) begin
      @(posedge clk); #1;
      if (rand_full) byte_fifo_full = ($urandom_range(0, 3) == 0);
      k++;
    end
    byte_fifo_full = 1'b0;
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    byte_fifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (resp_fifo_rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got %b want 0", resp_fifo_rd_en); end
    checks++; if (byte_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got %b want 0", byte_fifo_wr_en); end
    checks++; if (byte_fifo_wr_data !== 8'h00) begin failures++; $display("FAIL reset_wr_data got %h want 00", byte_fifo_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_write_ack();
    resp_packet_t p;
    int rd0, dn0, pe0, be0, t0;
    clear_obs();
    rd0 = rd_cnt; dn0 = done_cnt; pe0 = proto_err; be0 = busy_err;
    p = '{opcode: 8'h02, status: 8'h00, has_data: 1'b0, data: 32'h0};
    build_frame(p);
    t0 = cyc;
    pkt_q.push_back(p);
    wait_bytes(exp_q.size(), 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL ack_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL ack_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    if (obs_q.size() >= 3) begin
      checks++; if (obs_q[0].c != t0 + 1) begin failures++; $display("FAIL ack_latency got cycle %0d want %0d", obs_q[0].c, t0 + 1); end
      checks++; if (obs_q[2].c - obs_q[0].c != 2) begin failures++; $display("FAIL ack_consecutive got span %0d want 2", obs_q[2].c - obs_q[0].c); end
      checks++; if (done_cyc_q.size() != 1 || done_cyc_q[0] != obs_q[obs_q.size()-1].c + 1) begin
        failures++; $display("FAIL ack_frame_done got %0d pulses want 1 pulse after last byte", done_cyc_q.size()); end
    end
    checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL ack_rd_en got %0d pulses want 1", rd_cnt - rd0); end
    checks++; if (done_cnt - dn0 != 1) begin failures++; $display("FAIL ack_done_cnt got %0d want 1", done_cnt - dn0); end
    checks++; if (proto_err != pe0 || busy_err != be0) begin failures++; $display("FAIL ack_protocol got %0d/%0d errors want 0", proto_err - pe0, busy_err - be0); end
  endtask

  task automatic test_read_resp();
    resp_packet_t p;
    int rd0;
    clear_obs();
    rd0 = rd_cnt;
    p = '{opcode: 8'h01, status: 8'h00, has_data: 1'b1, data: 32'hDEADBEEF};
    build_frame(p);
    pkt_q.push_back(p);
    wait_bytes(exp_q.size(), 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL read_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL read_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL read_rd_en got %0d pulses want 1", rd_cnt - rd0); end
  endtask

  task automatic test_stall();
    resp_packet_t p;
    int k = 0;
    int pe0;
    clear_obs();
    pe0 = proto_err;
    p = '{opcode: 8'h01, status: 8'h00, has_data: 1'b1, data: 32'hDEADBEEF};
    build_frame(p);
    pkt_q.push_back(p);
    while (obs_q.size() < 3 && k < 200) begin @(posedge clk); k++; end
    #1 byte_fifo_full = 1'b1;
    repeat (5) @(posedge clk);
    #1 byte_fifo_full = 1'b0;
    wait_bytes(exp_q.size(), 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL stall_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL stall_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    if (obs_q.size() >= 4) begin
      checks++; if (obs_q[3].c - obs_q[2].c != 6) begin failures++; $display("FAIL stall_resume got gap %0d want 6", obs_q[3].c - obs_q[2].c); end
    end
    checks++; if (proto_err != pe0) begin failures++; $display("FAIL stall_write_while_full got %0d want 0", proto_err - pe0); end
  endtask

  task automatic test_back_to_back();
    resp_packet_t p1, p2;
    int rd0, dn0, len1;
    clear_obs();
    rd0 = rd_cnt; dn0 = done_cnt;
    p1 = rand_pkt(); p2 = rand_pkt();
    p2.opcode = ~p1.opcode;
    build_frame(p1);
    len1 = exp_q.size();
    build_frame(p2);
    pkt_q.push_back(p1); pkt_q.push_back(p2);
    wait_bytes(exp_q.size(), 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL b2b_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL b2b_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    if (obs_q.size() > len1) begin
      checks++; if (obs_q[len1].c - obs_q[len1-1].c != 3) begin failures++; $display("FAIL b2b_gap got %0d want 3", obs_q[len1].c - obs_q[len1-1].c); end
    end
    checks++; if (rd_cnt - rd0 != 2) begin failures++; $display("FAIL b2b_rd_en got %0d pulses want 2", rd_cnt - rd0); end
    checks++; if (done_cnt - dn0 != 2) begin failures++; $display("FAIL b2b_done got %0d want 2", done_cnt - dn0); end
  endtask

  task automatic test_random();
    int rd0, dn0, pe0, be0;
    int n = 16;
    clear_obs();
    rd0 = rd_cnt; dn0 = done_cnt; pe0 = proto_err; be0 = busy_err;
    for (int i = 0; i < n; i++) begin
      resp_packet_t p;
      p = rand_pkt();
      build_frame(p);
      pkt_q.push_back(p);
    end
    wait_bytes(exp_q.size(), 1'b1);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL rand_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL rand_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    checks++; if (rd_cnt - rd0 != n) begin failures++; $display("FAIL rand_rd_en got %0d want %0d", rd_cnt - rd0, n); end
    checks++; if (done_cnt - dn0 != n) begin failures++; $display("FAIL rand_done got %0d want %0d", done_cnt - dn0, n); end
    checks++; if (proto_err != pe0 || busy_err != be0) begin failures++; $display("FAIL rand_protocol got %0d/%0d errors want 0", proto_err - pe0, busy_err - be0); end
  endtask

  task automatic test_reset_midframe();
    resp_packet_t p1, p2;
    int k = 0;
    int rd0;
    clear_obs();
    p1 = rand_pkt(); p1.has_data = 1'b1;
    p2 = rand_pkt();
    pkt_q.push_back(p1); pkt_q.push_back(p2);
    while (obs_q.size() < 4 && k < 200) begin @(posedge clk); k++; end
    @(negedge clk); #2 rst = 1'b0;
    #1;
    checks++; if (byte_fifo_wr_en !== 1'b0) begin failures++; $display("FAIL abort_wr_en got %b want 0", byte_fifo_wr_en); end
    checks++; if (byte_fifo_wr_data !== 8'h00) begin failures++; $display("FAIL abort_wr_data got %h want 00", byte_fifo_wr_data); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (resp_fifo_rd_en !== 1'b0 || frame_done !== 1'b0) begin failures++; $display("FAIL abort_pulses got rd_en=%b done=%b want 0", resp_fifo_rd_en, frame_done); end
    repeat (2) @(posedge clk);
    clear_obs();
    rd0 = rd_cnt;
    build_frame(p2);
    @(negedge clk); #2 rst = 1'b1;
    wait_bytes(exp_q.size(), 1'b0);
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL resume_len got %0d want %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++; if (obs_q[i].b !== exp_q[i]) begin failures++; $display("FAIL resume_byte%0d got %h want %h", i, obs_q[i].b, exp_q[i]); end
    end
    checks++; if (rd_cnt - rd0 != 1) begin failures++; $display("FAIL resume_rd_en got %0d want 1", rd_cnt - rd0); end
  endtask

  initial begin
    test_reset();
    test_write_ack();
    test_read_resp();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
